// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI target.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT
   } spi_state_e;

   localparam int SPI_WIDTH_DEFAULT = 8;
   localparam int SPI_SYNC_DEFAULT  = 2;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pins plus fabric-side transmit/receive handshake of the SPI target.
interface spi_slave_if
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WIDTH_DEFAULT
);

   logic             sclk;
   logic             ss;
   logic             mosi;
   logic             miso;
   logic             miso_oe;
   logic [WIDTH-1:0] tx_d;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_d;
   logic             rx_valid;
   logic             busy;
   logic             tx_underrun;

   modport slave (
      input  sclk, ss, mosi, tx_d, tx_valid,
      output miso, miso_oe, tx_ready, rx_d, rx_valid, busy, tx_underrun
   );

   modport master (
      output sclk, ss, mosi, tx_d, tx_valid,
      input  miso, miso_oe, tx_ready, rx_d, rx_valid, busy, tx_underrun
   );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered level and edge strobes.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int   STAGES = SPI_SYNC_DEFAULT,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;

   // q and both strobes share one register stage so they stay aligned
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= {STAGES{INIT}};
         q    <= INIT;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         q    <= sync[STAGES-1];
         rise <= sync[STAGES-1] & ~q;
         fall <= ~sync[STAGES-1] & q;
      end
   end

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI target: oversampled pins, one-entry tx buffer, rx strobe.
module spi_slave
   import spi_pkg::*;
#(
   parameter int WIDTH       = SPI_WIDTH_DEFAULT,
   parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
   input logic        clk,
   input logic        rst,
   spi_slave_if.slave bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic sclk_rise, sclk_fall, sclk_q_unused;
   logic ss_rise, ss_fall, ss_q;
   logic mosi_q, mosi_rise_unused, mosi_fall_unused;

   spi_state_e state, state_nx;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] tx_buf;
   logic             tx_full;
   logic             load_ok;
   logic [WIDTH-1:0] tx_shift;
   logic [WIDTH-2:0] rx_shift;
   logic [WIDTH-1:0] rx_d;
   logic             rx_valid;
   logic             underrun;
   logic             busy;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.sclk),
      .q    (sclk_q_unused),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_ss (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.ss),
      .q    (ss_q),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_mosi (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.mosi),
      .q    (mosi_q),
      .rise (mosi_rise_unused),
      .fall (mosi_fall_unused)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (ss_fall) state_nx = LOAD;
         LOAD:    state_nx = SHIFT;
         SHIFT:   state_nx = SHIFT;
         default: state_nx = IDLE;
      endcase
      if (ss_rise) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         tx_buf   <= '0;
         tx_full  <= 1'b0;
         load_ok  <= 1'b0;
         tx_shift <= '0;
         rx_shift <= '0;
         rx_d     <= '0;
         rx_valid <= 1'b0;
         underrun <= 1'b0;
         busy     <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         underrun <= 1'b0;
         busy     <= ~ss_q;
         if (bus.tx_valid && !tx_full) begin
            tx_buf  <= bus.tx_d;
            tx_full <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               cnt      <= '0;
               tx_shift <= '0;
               // snapshot taken before a same-cycle write can land
               load_ok  <= tx_full;
            end
            LOAD: begin
               if (load_ok) begin
                  tx_shift <= tx_buf;
                  tx_full  <= 1'b0;
               end else begin
                  tx_shift <= '0;
                  underrun <= 1'b1;
               end
            end
            SHIFT: begin
               if (sclk_rise) begin
                  if (cnt == LAST) begin
                     rx_d     <= {rx_shift, mosi_q};
                     rx_valid <= 1'b1;
                     cnt      <= '0;
                  end else begin
                     rx_shift <= (WIDTH-1)'({rx_shift, mosi_q});
                     cnt      <= cnt + 1'b1;
                  end
               end else if (sclk_fall && !ss_rise) begin
                  if (cnt != '0) begin
                     tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                  end else if (tx_full) begin
                     tx_shift <= tx_buf;
                     tx_full  <= 1'b0;
                  end else begin
                     tx_shift <= '0;
                     underrun <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
         if (ss_rise) cnt <= '0;
      end
   end

   assign bus.miso        = tx_shift[WIDTH-1];
   assign bus.miso_oe     = busy;
   assign bus.busy        = busy;
   assign bus.tx_ready    = ~tx_full;
   assign bus.rx_d        = rx_d;
   assign bus.rx_valid    = rx_valid;
   assign bus.tx_underrun = underrun;

endmodule

// File: tb/tb_spi_slave.sv
// Scenario bench for spi_slave: mode-0 master model plus rx scoreboard.
module tb_spi_slave;
   import spi_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   spi_slave_if #(.WIDTH(8)) bus ();

   spi_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] rx_exp[$];
   logic [7:0] rx_obs[$];
   int         urun_cnt = 0;
   int         n_checks = 0;
   int         n_fail   = 0;
   bit         oe_seen  = 0;

   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1) rx_obs.push_back(bus.rx_d);
      if (bus.tx_underrun === 1'b1) urun_cnt++;
      if (bus.miso_oe === 1'b1) oe_seen = 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic bit pop_obs(output logic [7:0] v);
      v = 8'hxx;
      if (rx_obs.size() == 0) return 1'b0;
      v = rx_obs.pop_front();
      return 1'b1;
   endfunction

   task automatic write_tx(input logic [7:0] d);
      int t = 0;
      while (bus.tx_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (bus.tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL tx_ready_wait: got %b want 1", bus.tx_ready);
      end
      bus.tx_d     = d;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic ss_low();
      bus.ss = 1'b0;
      wait_n(4);
   endtask

   // fSCLK = fclk/8; MISO sampled as SCLK rises; SS may rise with last fall
   task automatic xfer(input logic [7:0] mo, input int nbits,
                       input bit last, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         bus.mosi = mo[7-i];
         wait_n(4);
         bus.sclk = 1'b1;
         mi[7-i] = bus.miso;
         wait_n(4);
         bus.sclk = 1'b0;
         if (last && i == nbits - 1) bus.ss = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_n(3);
      rst = 1'b0;
      wait_n(1);
      n_checks++;
      if ({bus.miso, bus.miso_oe, bus.busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_pins: got %b want 000",
                  {bus.miso, bus.miso_oe, bus.busy});
      end
      n_checks++;
      if (bus.rx_d !== 8'h00 || bus.rx_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_rx: got %h/%b want 00/0", bus.rx_d, bus.rx_valid);
      end
      n_checks++;
      if (bus.tx_ready !== 1'b1 || bus.tx_underrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tx: got %b%b want 10", bus.tx_ready, bus.tx_underrun);
      end
   endtask

   task automatic test_single();
      logic [7:0] mi, obs, exp;
      int u0 = urun_cnt;
      write_tx(8'hA5);
      n_checks++;
      if (bus.tx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL single_full: tx_ready got %b want 0", bus.tx_ready);
      end
      rx_exp.push_back(8'h3C);
      ss_low();
      xfer(8'h3C, 8, 1'b1, mi);
      wait_n(12);
      n_checks++;
      if (mi !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_miso: got %h want a5", mi);
      end
      exp = rx_exp.pop_front();
      n_checks++;
      if (!pop_obs(obs) || obs !== exp) begin
         n_fail++;
         $display("FAIL single_rx: got %h want %h", obs, exp);
      end
      n_checks++;
      if (rx_obs.size() != 0) begin
         n_fail++;
         $display("FAIL single_rx_once: extra %0d pulses want 0", rx_obs.size());
         rx_obs.delete();
      end
      n_checks++;
      if (bus.tx_ready !== 1'b1 || urun_cnt != u0) begin
         n_fail++;
         $display("FAIL single_tx: ready %b urun %0d want 1 0",
                  bus.tx_ready, urun_cnt - u0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] m1, m2, obs, exp;
      int u0 = urun_cnt;
      write_tx(8'h11);
      rx_exp.push_back(8'hF0);
      rx_exp.push_back(8'h0F);
      ss_low();
      fork
         begin
            xfer(8'hF0, 8, 1'b0, m1);
            xfer(8'h0F, 8, 1'b1, m2);
         end
         write_tx(8'h22);
      join
      wait_n(12);
      n_checks++;
      if (m1 !== 8'h11 || m2 !== 8'h22) begin
         n_fail++;
         $display("FAIL b2b_miso: got %h %h want 11 22", m1, m2);
      end
      for (int k = 0; k < 2; k++) begin
         exp = rx_exp.pop_front();
         n_checks++;
         if (!pop_obs(obs) || obs !== exp) begin
            n_fail++;
            $display("FAIL b2b_rx%0d: got %h want %h", k, obs, exp);
         end
      end
      n_checks++;
      if (rx_obs.size() != 0 || urun_cnt != u0) begin
         n_fail++;
         $display("FAIL b2b_extra: rx %0d urun %0d want 0 0",
                  rx_obs.size(), urun_cnt - u0);
         rx_obs.delete();
      end
   endtask

   task automatic test_underrun();
      logic [7:0] mi, obs, exp;
      int u0 = urun_cnt;
      rx_exp.push_back(8'h55);
      ss_low();
      xfer(8'h55, 8, 1'b1, mi);
      wait_n(12);
      n_checks++;
      if (mi !== 8'h00) begin
         n_fail++;
         $display("FAIL urun_miso: got %h want 00", mi);
      end
      n_checks++;
      if (urun_cnt - u0 != 1) begin
         n_fail++;
         $display("FAIL urun_pulse: got %0d want 1", urun_cnt - u0);
      end
      exp = rx_exp.pop_front();
      n_checks++;
      if (!pop_obs(obs) || obs !== exp || bus.rx_d !== 8'h55) begin
         n_fail++;
         $display("FAIL urun_rx: got %h rx_d %h want %h", obs, bus.rx_d, exp);
      end
   endtask

   task automatic test_abort();
      logic [7:0] mi, obs, exp;
      ss_low();
      xfer(8'hFF, 5, 1'b1, mi);
      wait_n(12);
      n_checks++;
      if (rx_obs.size() != 0 || bus.rx_d !== 8'h55) begin
         n_fail++;
         $display("FAIL abort_rx: pulses %0d rx_d %h want 0 55",
                  rx_obs.size(), bus.rx_d);
         rx_obs.delete();
      end
      n_checks++;
      if (bus.miso_oe !== 1'b0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_oe: got %b%b want 00", bus.miso_oe, bus.busy);
      end
      rx_exp.push_back(8'h81);
      ss_low();
      xfer(8'h81, 8, 1'b1, mi);
      wait_n(12);
      exp = rx_exp.pop_front();
      n_checks++;
      if (!pop_obs(obs) || obs !== exp || bus.rx_d !== 8'h81) begin
         n_fail++;
         $display("FAIL abort_next: got %h rx_d %h want %h", obs, bus.rx_d, exp);
      end
   endtask

   task automatic test_glitch();
      oe_seen = 0;
      bus.ss = 1'b1;
      repeat (20) begin
         bus.sclk = ~bus.sclk;
         wait_n(2);
      end
      wait_n(8);
      n_checks++;
      if (rx_obs.size() != 0 || oe_seen) begin
         n_fail++;
         $display("FAIL glitch_out: pulses %0d oe %b want 0 0", rx_obs.size(), oe_seen);
         rx_obs.delete();
      end
      n_checks++;
      if (dut.cnt !== 3'd0 || dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL glitch_cnt: cnt %0d state %0d want 0 0", dut.cnt, dut.state);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] mi, obs, exp;
      int u0;
      write_tx(8'h99);
      ss_low();
      write_tx(8'h44);
      xfer(8'hE0, 3, 1'b0, mi);
      rst    = 1'b1;
      bus.ss = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({bus.miso, bus.miso_oe, bus.busy, bus.rx_valid, bus.tx_underrun} !== 5'b0) begin
         n_fail++;
         $display("FAIL rstmid_pins: got %b want 00000",
                  {bus.miso, bus.miso_oe, bus.busy, bus.rx_valid, bus.tx_underrun});
      end
      n_checks++;
      if (bus.rx_d !== 8'h00 || bus.tx_ready !== 1'b1 || dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL rstmid_regs: rx_d %h ready %b state %0d want 00 1 0",
                  bus.rx_d, bus.tx_ready, dut.state);
      end
      wait_n(10);
      n_checks++;
      if (bus.busy !== 1'b0 || dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL rstmid_idle: busy %b state %0d want 0 0", bus.busy, dut.state);
      end
      u0 = urun_cnt;
      rx_exp.push_back(8'h12);
      ss_low();
      xfer(8'h12, 8, 1'b1, mi);
      wait_n(12);
      n_checks++;
      if (mi !== 8'h00 || urun_cnt - u0 != 1) begin
         n_fail++;
         $display("FAIL rstmid_buf: miso %h urun %0d want 00 1", mi, urun_cnt - u0);
      end
      exp = rx_exp.pop_front();
      n_checks++;
      if (!pop_obs(obs) || obs !== exp) begin
         n_fail++;
         $display("FAIL rstmid_rx: got %h want %h", obs, exp);
      end
   endtask

   initial begin
      bus.sclk     = 1'b0;
      bus.ss       = 1'b1;
      bus.mosi     = 1'b0;
      bus.tx_d     = 8'h00;
      bus.tx_valid = 1'b0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_underrun();
      test_abort();
      test_glitch();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
